// File: rtl/w_writeback.sv
// Write-back stage: M/W pipeline register, load extraction, write-back select,
// misaligned-load detection and retired-instruction counting.

module w_load_ext (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  loadop,
  output logic [31:0] data
);
  localparam logic [2:0] LD_B = 3'd1, LD_BU = 3'd2, LD_H = 3'd3, LD_HU = 3'd4;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Codes 5-7 fall into the default and behave as LW.
  always_comb begin
    data = word;
    case (loadop)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0, half_sel};
      default: data = word;
    endcase
  end
endmodule

module w_writeback #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic        M_GRFwrite,
  input  logic [4:0]  M_WR,
  input  logic [31:0] M_ALUres,
  input  logic [31:0] M_DMdata,
  input  logic [2:0]  M_loadop,
  input  logic [1:0]  M_WDsel,
  input  logic [31:0] M_PC,
  output logic        GRFwrite,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic [31:0] W_PC,
  output logic        W_misalign,
  output logic [31:0] W_misalign_PC,
  output logic [31:0] W_instret
);
  localparam logic [2:0] LD_B = 3'd1, LD_BU = 3'd2, LD_H = 3'd3, LD_HU = 3'd4;
  localparam logic [1:0] WD_ALU = 2'd0, WD_DM = 2'd1, WD_PC8 = 2'd2;

  typedef struct packed {
    logic        grfwrite;
    logic        mis;
    logic [4:0]  wr;
    logic [31:0] alures;
    logic [31:0] dmdata;
    logic [2:0]  loadop;
    logic [1:0]  wdsel;
    logic [31:0] pc;
  } w_reg_t;

  w_reg_t      w_q, w_d;
  logic [1:0]  vld_pipe;
  logic        m_mis;
  logic        m_retire;
  logic        mis_q;
  logic [31:0] mis_pc_q;
  logic [31:0] instret_q;
  logic [31:0] ld_data;

  // Misalignment is decoded on the M side so the W flag, the suppressed write
  // and the retire count all land on the same edge as the capture.
  always_comb begin
    m_mis = 1'b0;
    if (M_valid && M_WDsel == WD_DM) begin
      case (M_loadop)
        LD_B, LD_BU: m_mis = 1'b0;
        LD_H, LD_HU: m_mis = M_ALUres[0];
        default:     m_mis = (M_ALUres[1:0] != 2'd0);
      endcase
    end
  end

  assign vld_pipe[0] = M_valid;
  assign m_retire    = M_valid && !m_mis;

  always_comb begin
    w_d          = '0;
    w_d.grfwrite = M_GRFwrite;
    w_d.mis      = m_mis;
    w_d.wr       = M_WR;
    w_d.alures   = M_ALUres;
    w_d.dmdata   = M_DMdata;
    w_d.loadop   = M_loadop;
    w_d.wdsel    = M_WDsel;
    w_d.pc       = M_PC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q         <= '0;
      w_q.pc      <= RESET_PC;
      vld_pipe[1] <= 1'b0;
      mis_q       <= 1'b0;
      mis_pc_q    <= '0;
      instret_q   <= '0;
    end else begin
      w_q         <= w_d;
      vld_pipe[1] <= vld_pipe[0];
      if (m_mis && !mis_q) begin
        mis_q    <= 1'b1;
        mis_pc_q <= M_PC;
      end
      if (m_retire) instret_q <= instret_q + 32'd1;
    end
  end

  w_load_ext u_ld (
    .word   (w_q.dmdata),
    .off    (w_q.alures[1:0]),
    .loadop (w_q.loadop),
    .data   (ld_data)
  );

  always_comb begin
    WD = w_q.alures;
    case (w_q.wdsel)
      WD_ALU:  WD = w_q.alures;
      WD_DM:   WD = ld_data;
      WD_PC8:  WD = w_q.pc + 32'd8;
      default: WD = w_q.alures;
    endcase
  end

  assign GRFwrite      = vld_pipe[1] && w_q.grfwrite && !w_q.mis;
  assign WR            = w_q.wr;
  assign W_PC          = w_q.pc;
  assign W_misalign    = mis_q;
  assign W_misalign_PC = mis_pc_q;
  assign W_instret     = instret_q;
endmodule

// File: tb/tb_w_writeback.sv
// Scoreboard bench for w_writeback: directed vectors push expected W outputs,
// a monitor pops and compares one entry after every capturing edge.

module tb_w_writeback;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        M_valid = 1'b0, M_GRFwrite = 1'b0;
  logic [4:0]  M_WR = '0;
  logic [31:0] M_ALUres = '0, M_DMdata = '0, M_PC = '0;
  logic [2:0]  M_loadop = '0;
  logic [1:0]  M_WDsel = '0;
  logic        GRFwrite, W_misalign;
  logic [4:0]  WR;
  logic [31:0] WD, W_PC, W_misalign_PC, W_instret;

  w_writeback #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .M_valid(M_valid), .M_GRFwrite(M_GRFwrite),
    .M_WR(M_WR), .M_ALUres(M_ALUres), .M_DMdata(M_DMdata), .M_loadop(M_loadop),
    .M_WDsel(M_WDsel), .M_PC(M_PC), .GRFwrite(GRFwrite), .WR(WR), .WD(WD),
    .W_PC(W_PC), .W_misalign(W_misalign), .W_misalign_PC(W_misalign_PC),
    .W_instret(W_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        grf;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        mis;
    logic [31:0] mpc;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;
  localparam logic [31:0] DM = 32'h80FF_7F01;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: one entry per capturing edge, sampled 2 time units after it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".GRFwrite"}, {31'h0, GRFwrite}, {31'h0, e.grf});
        chk({e.tag, ".WR"}, {27'h0, WR}, {27'h0, e.wr});
        chk({e.tag, ".WD"}, WD, e.wd);
        chk({e.tag, ".W_PC"}, W_PC, e.pc);
        chk({e.tag, ".W_misalign"}, {31'h0, W_misalign}, {31'h0, e.mis});
        chk({e.tag, ".W_misalign_PC"}, W_misalign_PC, e.mpc);
        chk({e.tag, ".W_instret"}, W_instret, e.ir);
      end
    end
  end

  task automatic rst_cycle(input string tag);
    exp_t e;
    @(negedge clk);
    reset = 1'b1; M_valid = 1'b1; M_GRFwrite = 1'b1; M_WR = 5'd9;
    M_ALUres = 32'hDEAD_BEE2; M_DMdata = DM; M_loadop = 3'd0; M_WDsel = 2'd1;
    M_PC = 32'h0000_4444;
    e = '{tag, 1'b0, 5'd0, 32'h0, 32'h0000_3000, 1'b0, 32'h0, 32'h0};
    q.push_back(e);
  endtask

  task automatic issue(input string tag, input logic v, input logic gw,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [2:0] lop, input logic [1:0] wsel,
                       input logic [31:0] pc, input logic e_grf,
                       input logic [31:0] e_wd, input logic e_mis,
                       input logic [31:0] e_mpc, input logic [31:0] e_ir);
    exp_t e;
    @(negedge clk);
    reset = 1'b0; M_valid = v; M_GRFwrite = gw; M_WR = wr; M_ALUres = alu;
    M_DMdata = DM; M_loadop = lop; M_WDsel = wsel; M_PC = pc;
    e = '{tag, e_grf, wr, e_wd, pc, e_mis, e_mpc, e_ir};
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rst_cycle("reset");
    //      tag        v  gw wr    alu            lop  sel  pc            grf wd             mis mpc            ir
    issue("alu",     1, 1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'h3004,      1, 32'h1234_5678, 0, 32'h0,      32'd1);
    issue("lb3",     1, 1, 5'd6, 32'h0000_1003, 3'd1, 2'd1, 32'h3008,      1, 32'hFFFF_FF80, 0, 32'h0,      32'd2);
    issue("lbu3",    1, 1, 5'd7, 32'h0000_1003, 3'd2, 2'd1, 32'h300C,      1, 32'h0000_0080, 0, 32'h0,      32'd3);
    issue("lb1",     1, 1, 5'd8, 32'h0000_1001, 3'd1, 2'd1, 32'h3010,      1, 32'h0000_007F, 0, 32'h0,      32'd4);
    issue("lh2",     1, 1, 5'd9, 32'h0000_1002, 3'd3, 2'd1, 32'h3014,      1, 32'hFFFF_80FF, 0, 32'h0,      32'd5);
    issue("lhu0",    1, 1, 5'd10, 32'h0000_1000, 3'd4, 2'd1, 32'h3018,     1, 32'h0000_7F01, 0, 32'h0,      32'd6);
    issue("lw0",     1, 1, 5'd11, 32'h0000_1000, 3'd0, 2'd1, 32'h301C,     1, 32'h80FF_7F01, 0, 32'h0,      32'd7);
    issue("link",    1, 1, 5'd31, 32'h0,         3'd0, 2'd2, 32'h0000_3010, 1, 32'h0000_3018, 0, 32'h0,     32'd8);
    issue("linkwrap",1, 1, 5'd31, 32'h0,         3'd0, 2'd2, 32'hFFFF_FFFC, 1, 32'h0000_0004, 0, 32'h0,     32'd9);
    issue("sel3",    1, 1, 5'd12, 32'hCAFE_0001, 3'd0, 2'd3, 32'h3024,     1, 32'hCAFE_0001, 0, 32'h0,      32'd10);
    issue("lop7",    1, 1, 5'd13, 32'h0000_2000, 3'd7, 2'd1, 32'h3028,     1, 32'h80FF_7F01, 0, 32'h0,      32'd11);
    issue("mislw",   1, 1, 5'd14, 32'h0000_0002, 3'd0, 2'd1, 32'h3020,     0, 32'h80FF_7F01, 1, 32'h3020,   32'd11);
    issue("aluodd",  1, 1, 5'd15, 32'h0000_0003, 3'd0, 2'd0, 32'h302C,     1, 32'h0000_0003, 1, 32'h3020,   32'd12);
    issue("mislh",   1, 1, 5'd16, 32'h0000_0001, 3'd3, 2'd1, 32'h3030,     0, 32'h0000_7F01, 1, 32'h3020,   32'd12);
    issue("nowrite", 1, 0, 5'd17, 32'h0000_0011, 3'd0, 2'd0, 32'h3034,     0, 32'h0000_0011, 1, 32'h3020,   32'd13);
    issue("wr0",     1, 1, 5'd0,  32'h0000_0022, 3'd0, 2'd0, 32'h3038,     1, 32'h0000_0022, 1, 32'h3020,   32'd14);
    for (int i = 0; i < 8; i++) begin
      logic v;
      v = (i % 2 == 0);
      issue("bubble", v, 1, 5'd3, 32'h100 + i, 3'd0, 2'd0, 32'h3040 + 4 * i,
            v, 32'h100 + i, 1, 32'h3020, 32'd15 + i / 2);
    end
    rst_cycle("midreset");
    issue("bubmis",  0, 1, 5'd4, 32'h0000_0002, 3'd0, 2'd1, 32'h3060,      0, 32'h80FF_7F01, 0, 32'h0,      32'd0);
    issue("after",   1, 1, 5'd4, 32'h0000_0044, 3'd0, 2'd0, 32'h3064,      1, 32'h0000_0044, 0, 32'h0,      32'd1);
    // Preload the counter just below wrap, then retire one instruction.
    issue("wrap",    1, 1, 5'd2, 32'h0000_0055, 3'd0, 2'd0, 32'h3068,      1, 32'h0000_0055, 0, 32'h0,      32'd0);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    issue("postwrap",1, 1, 5'd2, 32'h0000_0066, 3'd0, 2'd0, 32'h306C,      1, 32'h0000_0066, 0, 32'h0,      32'd1);
    @(negedge clk);
    M_valid = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/w_writeback.md
# w_writeback

Write-back stage of the five-stage pipeline. Registers memory-stage results at the M/W boundary, extracts and extends load data, selects the write-back value, and drives the register file write port (write enable, destination, data, PC for the commit trace). It also supplies the W-stage forwarding value, counts retired instructions, and flags misaligned loads.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value of W_PC after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- M_valid  in  1  M stage holds a real instruction (0 = bubble).
- M_GRFwrite  in  1  instruction writes a GPR.
- M_WR  in  5  destination register.
- M_ALUres  in  32  ALU result; for loads, the effective address.
- M_DMdata  in  32  raw aligned word read from data memory.
- M_loadop  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- M_WDsel  in  2  0 ALU, 1 DM (load), 2 PC+8 (link), 3 treated as ALU.
- M_PC  in  32  instruction PC.
- GRFwrite  out  1  register file write enable.
- WR  out  5  register file write address.
- WD  out  32  register file write data; also the W forwarding value.
- W_PC  out  32  PC of the instruction in W.
- W_misalign  out  1  sticky misaligned-load flag.
- W_misalign_PC  out  32  PC of the first misaligned load.
- W_instret  out  32  retired-instruction count.

## Operation
- Pipeline register: on each posedge, capture all M_* inputs into W-stage registers. There is no stall or flush input; the W stage always advances.
- Byte offset: off = registered M_ALUres[1:0].
- Load extraction, from registered DMdata:
  - LB/LBU select byte off (off 0 = bits 7:0; off 3 = bits 31:24); LB sign-extends and LBU zero-extends to 32 bits.
  - LH/LHU select half off[1] (0 = bits 15:0); LH sign-extends and LHU zero-extends.
  - LW passes the word through.
- WD select: ALU gives registered ALUres; DM gives the extracted load data; PC+8 gives registered PC + 32'd8, computed modulo 2^32.
- Misalignment applies only when WDsel = DM and valid:
  - LH/LHU with off[0] = 1, or LW with off ≠ 0, is misaligned.
  - A misaligned load suppresses its write: GRFwrite = 0.
  - It sets W_misalign. If the flag was previously clear, its PC is latched into W_misalign_PC. Later misaligned loads do not overwrite it.
  - W_misalign clears only on reset.
- GRFwrite = valid AND M_GRFwrite AND NOT misaligned.
- WR = 0 with GRFwrite = 1 is passed through unchanged; the register file discards the write.
- W_instret increments by 1 on the posedge after each valid, non-misaligned instruction is captured, whether or not it writes. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- Latency: M inputs to W outputs is exactly 1 cycle. GRFwrite, WR, WD and W_PC reflect the instruction captured at the preceding posedge.
- WD is combinational from W registers only, with no path from M_* inputs within a cycle. The register file writes it at the following posedge, so each instruction commits 2 edges after it appears at M.
- Reset values:
  - GRFwrite 0, WR 0, W_PC = RESET_PC, W_misalign 0, W_misalign_PC 0, W_instret 0.
  - All other W registers reset to 0, so WD = 0 (WDsel ALU, ALUres 0).
- Reset asserted mid-stream: the instruction presented that cycle is discarded, neither captured nor counted. Capture resumes on the first posedge with reset low.
- A bubble (M_valid = 0) gives GRFwrite = 0 and no count. WR, WD and W_PC still follow the captured fields but carry no meaning.
- Back-to-back instructions are each captured and committed with no gaps.

## Test plan
- Reset → GRFwrite 0, W_PC 32'h0000_3000, W_instret 0, W_misalign 0. Hold reset 3 cycles with M_valid = 1: outputs stay at reset values.
- ALU write: M_valid 1, GRFwrite 1, WR 5, WDsel ALU, ALUres 32'h1234_5678, PC 32'h3004 → next cycle GRFwrite 1, WR 5, WD 32'h1234_5678, W_PC 32'h3004, W_instret 1.
- Loads with DMdata 32'h80FF_7F01:
  - LB off 3 → 32'hFFFF_FF80.
  - LBU off 3 → 32'h0000_0080.
  - LB off 1 → 32'h0000_007F.
  - LH off 2 → 32'hFFFF_80FF.
  - LHU off 0 → 32'h0000_7F01.
- Link: WDsel PC+8, PC 32'h0000_3010 → WD 32'h0000_3018. With PC 32'hFFFF_FFFC → WD 32'h0000_0004.
- Misalignment:
  - LW at ALUres 32'h0000_0002, PC 32'h3020 → GRFwrite 0, W_misalign 1, W_misalign_PC 32'h3020, instret unchanged.
  - A later LH at odd address, PC 32'h3030 → W_misalign_PC stays 32'h3020.
- Bubbles and wrap:
  - Alternate M_valid 1/0 for 8 cycles → GRFwrite pulses on 4 cycles, W_instret +4.
  - Force counter to 32'hFFFF_FFFF via a valid stream → next retirement gives 0.
